v20_pulse_gen: RTL and testbench
================================

Name: v20_pulse_gen

Overview:
- Synthetic detector-pulse source that emulates the ADC feeding the trapezoidal shaper.
- Each pulse is an instantaneous step of programmable amplitude followed by an exponential decay with time constant M clocks, the shape the shaper's M-parameter pole-zero term cancels.
- Pulses are fired by an external trigger or by an internal period counter. Overlapping pulses pile up with saturation.
- Output drives the shaper's input_data directly for bench and on-board self-test.

Parameters:
- SIZE_ADC_DATA, 16, width of output sample and amplitude.
- M, 16, decay time constant in clocks; power of two, 2..256; MSHIFT = log2(M).
- PERIOD, 64, auto-trigger interval in clocks, >= 2.
- SIZE_CNT, 16, period counter width; must hold PERIOD-1.

Ports:
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: 1 = triggers accepted; 0 = triggers ignored, decay continues.
- trig, input, 1: external trigger, sampled each rising edge.
- auto_mode, input, 1: 1 = internal periodic trigger active.
- amplitude, input, SIZE_ADC_DATA: step height added per accepted trigger, sampled on the trigger edge.
- output_data, output, SIZE_ADC_DATA: registered pulse sample.
- pulse_start, output, 1: one-cycle strobe, high in the cycle output_data first shows an accepted trigger.
- busy, output, 1: 1 while the accumulator is non-zero.

Behaviour:
- Reset (reset=0, async):
  - Accumulator, output_data, pulse_start, busy and period counter are all 0 immediately.
  - A reset mid-pulse aborts the pulse; there is no residual tail after release.
- Decay function dec(a):
  - if a >> MSHIFT != 0: a - (a >> MSHIFT);
  - else if a != 0: a - 1 (linear tail guarantees termination);
  - else 0.
- Effective trigger: fire = enable & (trig | auto_fire). Simultaneous external and auto trigger count once.
- Accumulator update per edge:
  - fire: acc <= min(dec(acc) + amplitude, 2^SIZE_ADC_DATA - 1). Compute at SIZE_ADC_DATA+1 bits, then saturate.
  - else: acc <= dec(acc).
- output_data is the acc register. Latency: trigger sampled at edge n means output_data = amplitude after edge n (visible in cycle n+1) when previously idle.
- pulse_start <= fire, so it is aligned with the step on output_data. Also high when amplitude = 0.
- busy = (acc != 0), registered alongside acc.
- State machine: IDLE (acc = 0) and DECAY (acc != 0).
  - IDLE -> DECAY on fire with amplitude != 0.
  - DECAY -> IDLE when dec(acc) reaches 0 with no fire.
  - DECAY -> DECAY on fire (pile-up).
- Period counter:
  - Cleared while auto_mode = 0 or enable = 0.
  - Otherwise increments each edge.
  - auto_fire = (cnt == PERIOD-1); the counter wraps to 0 on that edge.
  - First auto pulse_start appears after the PERIOD-th edge with auto_mode = enable = 1. Subsequent pulses are exactly PERIOD clocks apart.
- External triggers do not reset the period counter.
- trig held high fires every cycle (continuous pile-up); no edge detection.
- amplitude changes outside trigger edges have no effect.

Test Plan:
- Single pulse: reset release, amplitude = 1600, trig for one cycle -> output_data 1600, 1500, 1407, 1320 on successive cycles; pulse_start high only with 1600; busy = 1.
- Tail: drive the accumulator to 20 (amplitude = 20, trig once) -> 20, 19, 18, 17, 16, 15, 14, ..., 1, 0; busy falls with output 0; state returns to IDLE.
- Pile-up/saturation: amplitude = 60000, trig two consecutive cycles -> 60000 then 65535 (56250 + 60000 saturated); pulse_start high both cycles.
- Auto mode: PERIOD = 64, amplitude = 100, auto_mode = enable = 1 -> pulse_start every 64 clocks, first after 64th edge. An external trig coinciding with auto_fire -> one add of 100 only.
- Enable gating: enable = 0, trig pulsed during decay from 1600 -> trigger ignored, decay unaffected, no pulse_start; period counter stays 0.
- Async reset mid-decay: assert reset = 0 between edges while output = 1407 -> output_data, busy, pulse_start = 0 immediately. After release with no trig, output stays 0.

Source files
------------

// File: rtl/v20_pulse_gen.sv
// Synthetic detector-pulse source: programmable step plus exponential decay
// (time constant M clocks) with saturating pile-up, fired externally or by a period counter.
module v20_pulse_gen #(
  parameter int SIZE_ADC_DATA = 16,
  parameter int M             = 16,
  parameter int PERIOD        = 64,
  parameter int SIZE_CNT      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     trig,
  input  logic                     auto_mode,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     pulse_start,
  output logic                     busy
);

  localparam int MSHIFT = $clog2(M);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DECAY = 1'b1;

  logic [SIZE_ADC_DATA-1:0] acc, acc_shr, acc_dec, acc_nxt;
  logic [SIZE_ADC_DATA:0]   acc_sum;
  logic [SIZE_CNT-1:0]      cnt;
  logic [0:0]               state, state_nxt;
  logic                     auto_fire, fire;

  // Period counter: idles at 0 unless both auto_mode and enable are set.
  assign auto_fire = auto_mode && (cnt == SIZE_CNT'(PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    cnt <= '0;
    else if (!auto_mode || !enable) cnt <= '0;
    else if (auto_fire)            cnt <= '0;
    else                           cnt <= cnt + SIZE_CNT'(1);
  end

  assign fire = enable & (trig | auto_fire);

  // Exponential decay; once the shifted term vanishes a linear tail of -1
  // guarantees the accumulator reaches zero.
  assign acc_shr = acc >> MSHIFT;

  always_comb begin
    acc_dec = '0;
    if (acc_shr != '0)   acc_dec = acc - acc_shr;
    else if (acc != '0)  acc_dec = acc - SIZE_ADC_DATA'(1);
  end

  assign acc_sum = {1'b0, acc_dec} + {1'b0, amplitude};

  always_comb begin
    acc_nxt = acc_dec;
    if (fire) acc_nxt = acc_sum[SIZE_ADC_DATA] ? '1 : acc_sum[SIZE_ADC_DATA-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire && acc_nxt != '0) state_nxt = DECAY;
      DECAY:   if (acc_nxt == '0)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      state       <= IDLE;
      pulse_start <= 1'b0;
    end else begin
      acc         <= acc_nxt;
      state       <= state_nxt;
      pulse_start <= fire;
    end
  end

  assign output_data = acc;
  assign busy        = (state == DECAY);

endmodule

// File: tb/tb_v20_pulse_gen.sv
// Directed bench for v20_pulse_gen: vector table for single-cycle steps,
// hand sequences for tail, auto period and async reset.
module tb_v20_pulse_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic        auto_mode = 1'b0;
  logic [15:0] amplitude = '0;
  logic [15:0] output_data;
  logic        pulse_start;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  v20_pulse_gen #(.SIZE_ADC_DATA(16), .M(16), .PERIOD(64), .SIZE_CNT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trig(trig), .auto_mode(auto_mode),
    .amplitude(amplitude), .output_data(output_data), .pulse_start(pulse_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        trg;
    logic        en;
    logic [15:0] amp;
    logic [15:0] eout;
    logic        eps;
    logic        ebusy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Drive at negedge, clock one edge, sample 1ns after the edge.
  task automatic step(input logic t, input logic en, input logic am, input logic [15:0] amp);
    @(negedge clk);
    trig = t; enable = en; auto_mode = am; amplitude = amp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'd1600,  16'd1600,  1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'd1600,  16'd1500,  1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'd1600,  16'd1407,  1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'd9999,  16'd1320,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'd5000,  16'd1238,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'd5000,  16'd1161,  1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'd60000, 16'd60000, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'd60000, 16'd65535, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'd60000, 16'd61440, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'd0,     16'd0,     1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'd0,     16'd0,     1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 16'd20,    16'd20,    1'b1, 1'b1};

    // Reset state (reset asserted from time 0)
    #3;
    check("reset_out",   output_data, 0);
    check("reset_ps",    pulse_start, 0);
    check("reset_busy",  busy, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].trg, vecs[i].en, 1'b0, vecs[i].amp);
      check($sformatf("vec%0d_out", i),  output_data, vecs[i].eout);
      check($sformatf("vec%0d_ps", i),   pulse_start, vecs[i].eps);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
    end

    // Linear tail from 20: each value drops by one, busy falls with zero
    for (int v = 19; v >= 0; v--) begin
      step(1'b0, 1'b1, 1'b0, 16'd20);
      check($sformatf("tail%0d_out", v), output_data, v);
      check($sformatf("tail%0d_busy", v), busy, (v != 0) ? 1 : 0);
      check($sformatf("tail%0d_ps", v), pulse_start, 0);
    end
    step(1'b0, 1'b1, 1'b0, 16'd20);
    check("tail_idle_out", output_data, 0);

    // Auto mode: first strobe after the 64th edge, then every 64 edges;
    // coincident external trigger adds amplitude once.
    do_reset();
    for (int e = 1; e <= 128; e++) begin
      step((e == 128) ? 1'b1 : 1'b0, 1'b1, 1'b1, 16'd100);
      if (e == 64 || e == 128) begin
        check($sformatf("auto_e%0d_ps", e), pulse_start, 1);
        check($sformatf("auto_e%0d_out", e), output_data, 100);
      end else begin
        check($sformatf("auto_e%0d_ps", e), pulse_start, 0);
      end
    end
    step(1'b0, 1'b1, 1'b1, 16'd100);
    check("auto_post_out", output_data, 94);

    // Enable low keeps the period counter cleared: re-enabling restarts the full period
    for (int e = 1; e <= 10; e++) step(1'b0, 1'b0, 1'b1, 16'd100);
    for (int e = 1; e <= 64; e++) begin
      step(1'b0, 1'b1, 1'b1, 16'd100);
      if (e == 64) check("reen_e64_ps", pulse_start, 1);
      else if (e == 1 || e == 63) check($sformatf("reen_e%0d_ps", e), pulse_start, 0);
    end

    // Async reset mid-decay while output shows 1407
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'd1600);
    step(1'b0, 1'b1, 1'b0, 16'd1600);
    step(1'b0, 1'b1, 1'b0, 16'd1600);
    check("arst_pre_out", output_data, 1407);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out",  output_data, 0);
    check("arst_busy", busy, 0);
    check("arst_ps",   pulse_start, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step(1'b0, 1'b1, 1'b0, 16'd1600);
      check($sformatf("arst_post%0d_out", e), output_data, 0);
      check($sformatf("arst_post%0d_busy", e), busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
